// File: rtl/iso_tx_core.sv
// iso_tx_core: ISO7816-style byte serializer with holding register, parity and stop bits.
// Latency: 2 cycles from an accepted loadDataIn to the start bit; back-to-back frames have no idle gap.
// Backpressure: full=1 means the holding register is occupied; a load while full is dropped and flagged.
//
// Ports: clk/reset (sync, active high); dataIn+loadDataIn write the holding register;
//   clocksPerBit = bit period - 1; stopBit2/oddParity/msbFirst are frame options latched at frame start;
//   ackFlags clears the sticky error flags; serialIn is line readback; serialOut is the line;
//   full/run/stopBit/endOfTx report progress; overrunErrorFlag/frameErrorFlag are sticky errors.
// Build option: define ISO_TX_ERROR_SIGNAL_EN to enable receiver error-signal detection
//   (mid-STOP1 readback, GUARD state, up to 3 retransmissions, frameErrorFlag).
module iso_tx_core #(
   parameter int   CLOCK_PER_BIT_WIDTH = 13,
   parameter logic START_BIT           = 1'b0,
   parameter logic STOP_BIT1           = 1'b1,
   parameter logic STOP_BIT2           = 1'b1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [7:0]                     dataIn,
   input  logic                           loadDataIn,
   input  logic [CLOCK_PER_BIT_WIDTH-1:0] clocksPerBit,
   input  logic                           stopBit2,
   input  logic                           oddParity,
   input  logic                           msbFirst,
   input  logic                           ackFlags,
   input  logic                           serialIn,
   output logic                           serialOut,
   output logic                           full,
   output logic                           run,
   output logic                           stopBit,
   output logic                           endOfTx,
   output logic                           overrunErrorFlag,
   output logic                           frameErrorFlag
);

`ifdef ISO_TX_ERROR_SIGNAL_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, GUARD} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;
`endif

   state_t                         state_q, state_d;
   logic [CLOCK_PER_BIT_WIDTH-1:0] cnt_q, cnt_d;
   logic [2:0]                     idx_q, idx_d;     // data bit index; reused as guard bit count
   logic [7:0]                     hold_q, hold_d;
   logic                           full_q, full_d;
   logic [7:0]                     data_q, data_d;   // byte on the line, kept intact for retransmission
   logic                           stop2_q, stop2_d;
   logic                           odd_q, odd_d;
   logic                           msb_q, msb_d;
   logic                           ovr_q, ovr_d;
   logic                           bit_end;
   logic                           last;             // final cycle of the final stop bit
   logic                           take;             // holding register -> frame byte

`ifdef ISO_TX_ERROR_SIGNAL_EN
   logic [1:0] retry_q, retry_d;
   logic       nack_q, nack_d;
   logic       ferr_q, ferr_d;
   logic       ferr_evt;
`else
   logic       unused_serial_in;
   assign unused_serial_in = serialIn;
`endif

   assign bit_end = (cnt_q == clocksPerBit);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      hold_d  = hold_q;
      full_d  = full_q;
      data_d  = data_q;
      stop2_d = stop2_q;
      odd_d   = odd_q;
      msb_d   = msb_q;
      last    = 1'b0;
      take    = 1'b0;
`ifdef ISO_TX_ERROR_SIGNAL_EN
      retry_d  = retry_q;
      nack_d   = nack_q;
      ferr_evt = 1'b0;
`endif
      // Bit timer idles at 0 so a frame always begins on a fresh bit period.
      cnt_d = (state_q == IDLE || bit_end) ? '0 : cnt_q + 1'b1;

      if (loadDataIn && !full_q) begin
         hold_d = dataIn;
         full_d = 1'b1;
      end
      // A simultaneous new overrun wins over the acknowledge.
      ovr_d = (ovr_q & ~ackFlags) | (loadDataIn & full_q);

      case (state_q)
         IDLE: begin
            if (full_q) begin
               take    = 1'b1;
               state_d = START;
            end
         end
         START: begin
            if (bit_end) begin
               state_d = DATA;
               idx_d   = 3'd0;
            end
         end
         DATA: begin
            if (bit_end) begin
               if (idx_q == 3'd7) state_d = PARITY;
               else               idx_d   = idx_q + 3'd1;
            end
         end
         PARITY: begin
            if (bit_end) state_d = STOP1;
         end
         STOP1: begin
`ifdef ISO_TX_ERROR_SIGNAL_EN
            // Receiver pulls the line low mid-stop-bit to request a repeat.
            if (cnt_q == (clocksPerBit >> 1) && !serialIn) begin
               if (retry_q == 2'd3) ferr_evt = 1'b1;
               else                 nack_d   = 1'b1;
            end
            if (bit_end) begin
               if (nack_q) begin
                  // Second stop bit is skipped: the guard time replaces it.
                  state_d = GUARD;
                  idx_d   = 3'd0;
                  nack_d  = 1'b0;
                  retry_d = retry_q + 2'd1;
               end else if (stop2_q) begin
                  state_d = STOP2;
               end else begin
                  last = 1'b1;
               end
            end
`else
            if (bit_end) begin
               if (stop2_q) state_d = STOP2;
               else         last    = 1'b1;
            end
`endif
         end
         STOP2: begin
            if (bit_end) last = 1'b1;
         end
`ifdef ISO_TX_ERROR_SIGNAL_EN
         GUARD: begin
            if (bit_end) begin
               if (idx_q == 3'd1) state_d = START;
               else               idx_d   = idx_q + 3'd1;
            end
         end
`endif
         default: state_d = IDLE;
      endcase

      if (last) begin
         if (full_q) begin
            take    = 1'b1;
            state_d = START;
         end else begin
            state_d = IDLE;
         end
      end

      // Frame options are frozen here so mid-frame input changes cannot corrupt the frame.
      if (take) begin
         data_d  = hold_q;
         full_d  = 1'b0;
         stop2_d = stopBit2;
         odd_d   = oddParity;
         msb_d   = msbFirst;
`ifdef ISO_TX_ERROR_SIGNAL_EN
         retry_d = 2'd0;
         nack_d  = 1'b0;
`endif
      end

`ifdef ISO_TX_ERROR_SIGNAL_EN
      ferr_d = (ferr_q & ~ackFlags) | ferr_evt;
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= 3'd0;
         hold_q  <= 8'd0;
         full_q  <= 1'b0;
         data_q  <= 8'd0;
         stop2_q <= 1'b0;
         odd_q   <= 1'b0;
         msb_q   <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         hold_q  <= hold_d;
         full_q  <= full_d;
         data_q  <= data_d;
         stop2_q <= stop2_d;
         odd_q   <= odd_d;
         msb_q   <= msb_d;
         ovr_q   <= ovr_d;
      end
   end

`ifdef ISO_TX_ERROR_SIGNAL_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         retry_q <= 2'd0;
         nack_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         retry_q <= retry_d;
         nack_q  <= nack_d;
         ferr_q  <= ferr_d;
      end
   end
   assign frameErrorFlag = ferr_q;
`else
   assign frameErrorFlag = 1'b0;
`endif

   always_comb begin
      serialOut = 1'b1;
      case (state_q)
         START:   serialOut = START_BIT;
         DATA:    serialOut = msb_q ? data_q[3'd7 - idx_q] : data_q[idx_q];
         PARITY:  serialOut = (^data_q) ^ odd_q;
         STOP1:   serialOut = STOP_BIT1;
         STOP2:   serialOut = STOP_BIT2;
         default: serialOut = 1'b1;
      endcase
   end

   assign full             = full_q;
   assign run              = (state_q != IDLE);
`ifdef ISO_TX_ERROR_SIGNAL_EN
   assign stopBit          = (state_q == STOP1) || (state_q == STOP2) || (state_q == GUARD);
`else
   assign stopBit          = (state_q == STOP1) || (state_q == STOP2);
`endif
   assign endOfTx          = last;
   assign overrunErrorFlag = ovr_q;

endmodule

// File: tb/tb_iso_tx_core.sv
// Testbench for iso_tx_core: randomized and directed loads, scoreboarded against a frame-level model.
module tb_iso_tx_core;
   localparam int W = 13;
`ifdef ISO_TX_ERROR_SIGNAL_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset, loadDataIn, stopBit2, oddParity, msbFirst, ackFlags, serialIn;
   logic [7:0]   dataIn;
   logic [W-1:0] clocksPerBit;
   logic         serialOut, full, run, stopBit, endOfTx, overrunErrorFlag, frameErrorFlag;
   logic         nack_mode = 1'b0;

   // Receiver loopback; in nack mode the receiver holds the line low to reject every frame.
   assign serialIn = nack_mode ? 1'b0 : serialOut;

   iso_tx_core #(.CLOCK_PER_BIT_WIDTH(W)) dut (
      .clk(clk), .reset(reset), .dataIn(dataIn), .loadDataIn(loadDataIn),
      .clocksPerBit(clocksPerBit), .stopBit2(stopBit2), .oddParity(oddParity),
      .msbFirst(msbFirst), .ackFlags(ackFlags), .serialIn(serialIn),
      .serialOut(serialOut), .full(full), .run(run), .stopBit(stopBit),
      .endOfTx(endOfTx), .overrunErrorFlag(overrunErrorFlag), .frameErrorFlag(frameErrorFlag)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [63:0] line;   // line level per bit, time order
      logic [63:0] stp;    // stopBit expected per bit
      int          nbits;
      int          cpb;
      int          start;  // cycle of the first start-bit cycle
   } frame_t;

   frame_t exp_q[$];
   int     n_cmp = 0;
   int     n_bad = 0;
   int     cpb_cur = 3;
   int     m_full_until = -1;   // last cycle the model says the holding register is occupied
   int     m_last_end = -1;     // endOfTx cycle of the last scheduled frame
   logic   mon_abort = 1'b1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Frame content from the protocol rules: start, 8 data bits, parity, stop(s);
   // each rejected attempt is followed by two guard bits and a full repeat.
   function automatic frame_t mk_frame(logic [7:0] d, logic ms, logic od, logic s2, int cpb, int retries);
      frame_t f;
      int     n = 0;
      logic   par;
      f.line = '0;
      f.stp  = '0;
      par = (($countones(d) % 2) == 1) ^ od;
      for (int a = 0; a <= retries; a++) begin
         f.line[n] = 1'b0; n++;
         for (int k = 0; k < 8; k++) begin
            f.line[n] = ms ? d[7-k] : d[k]; n++;
         end
         f.line[n] = par; n++;
         f.line[n] = 1'b1; f.stp[n] = 1'b1; n++;
         if (a < retries) begin
            for (int g = 0; g < 2; g++) begin
               f.line[n] = 1'b1; f.stp[n] = 1'b1; n++;
            end
         end else if (s2) begin
            f.line[n] = 1'b1; f.stp[n] = 1'b1; n++;
         end
      end
      f.nbits = n;
      f.cpb   = cpb;
      f.start = 0;
      return f;
   endfunction

   // Schedule a load issued in the current cycle; -1 means the holding register is occupied.
   function automatic int sched(int nbits, int cpb);
      int st;
      if (cyc <= m_full_until) return -1;
      st = (cyc + 2 > m_last_end + 1) ? cyc + 2 : m_last_end + 1;
      m_full_until = st - 1;
      m_last_end   = st + nbits * (cpb + 1) - 1;
      return st;
   endfunction

   // nlit > 0 selects a literal time-ordered bit table (leftmost bit first) instead of the model.
   task automatic load(input logic [7:0] d, input logic ms, input logic od, input logic s2,
                       input int retries, input logic [63:0] lit, input int nlit, input int nstop,
                       output int st);
      frame_t f;
      if (nlit > 0) begin
         f.line = '0;
         f.stp  = '0;
         for (int i = 0; i < nlit; i++) begin
            f.line[i] = lit[nlit-1-i];
            f.stp[i]  = (i >= nlit - nstop);
         end
         f.nbits = nlit;
         f.cpb   = cpb_cur;
         f.start = 0;
      end else begin
         f = mk_frame(d, ms, od, s2, cpb_cur, retries);
      end
      st = sched(f.nbits, f.cpb);
      if (st >= 0) begin
         f.start = st;
         exp_q.push_back(f);
         msbFirst  = ms;
         oddParity = od;
         stopBit2  = s2;
      end
      dataIn     = d;
      loadDataIn = 1'b1;
      tick();
      loadDataIn = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((cyc <= m_last_end || exp_q.size() != 0 || m_active) && n < 20000) begin
         tick();
         n++;
      end
      if (n >= 20000) check("drain_timeout", 32'd1, 32'd0);
      tick();
   endtask

   // Monitor: pops an expected frame when run rises and checks every cycle of it.
   logic   m_active = 1'b0;
   frame_t m_f;
   int     m_pos = 0;
   int     m_len = 0;
   int     m_bi;
   always @(negedge clk) begin
      if (mon_abort) begin
         m_active = 1'b0;
         exp_q.delete();
      end else begin
         if (!m_active) begin
            if (run) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_frame", 32'd1, 32'd0);
               end else begin
                  m_f      = exp_q.pop_front();
                  m_active = 1'b1;
                  m_pos    = 0;
                  m_len    = m_f.nbits * (m_f.cpb + 1);
                  check("frame_start_cycle", cyc, m_f.start);
               end
            end else begin
               check("idle_line", {serialOut, stopBit, endOfTx}, 3'b100);
            end
         end
         if (m_active) begin
            m_bi = m_pos / (m_f.cpb + 1);
            check("frame_cycle {line,run,stopBit,endOfTx}",
                  {serialOut, run, stopBit, endOfTx},
                  {m_f.line[m_bi], 1'b1, m_f.stp[m_bi], (m_pos == m_len - 1)});
            m_pos++;
            if (m_pos == m_len) m_active = 1'b0;
         end
      end
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int          st, st2, st3, st4;
      logic [63:0] lit;
      reset = 1'b1; loadDataIn = 1'b0; dataIn = 8'h00; ackFlags = 1'b0;
      stopBit2 = 1'b0; oddParity = 1'b0; msbFirst = 1'b0;
      cpb_cur = 3; clocksPerBit = W'(cpb_cur);
      repeat (3) tick();
      reset = 1'b0;
      mon_abort = 1'b0;
      check("reset_state", {serialOut, run, full, stopBit, endOfTx, overrunErrorFlag, frameErrorFlag}, 7'b1000000);
      tick();

      // 0x3B, LSB first, even parity, one stop bit, 4 cycles per bit.
      lit = 64'b0_1101_1100_1_1;
      load(8'h3B, 1'b0, 1'b0, 1'b0, 0, lit, 11, 1, st);
      wait_idle();

      // 0xA5, MSB first, odd parity, two stop bits.
      lit = 64'b0_1010_0101_1_1_1;
      load(8'hA5, 1'b1, 1'b1, 1'b1, 0, lit, 12, 2, st);
      wait_idle();

      // Back-to-back frames, overrun, and ack colliding with a new overrun.
      lit = 64'd0;
      load(8'h5A, 1'b0, 1'b0, 1'b0, 0, lit, 0, 0, st);
      repeat (10) tick();
      load(8'hC3, 1'b1, 1'b0, 1'b1, 0, lit, 0, 0, st2);
      repeat (3) tick();
      load(8'hFF, 1'b0, 1'b1, 1'b0, 0, lit, 0, 0, st3);
      check("overrun_set", overrunErrorFlag, (st3 < 0));
      ackFlags = 1'b1;
      tick();
      ackFlags = 1'b0;
      check("overrun_ack", overrunErrorFlag, 32'd0);
      ackFlags = 1'b1;
      load(8'h11, 1'b0, 1'b0, 1'b0, 0, lit, 0, 0, st4);
      ackFlags = 1'b0;
      check("overrun_ack_collide", overrunErrorFlag, (st4 < 0));
      ackFlags = 1'b1;
      tick();
      ackFlags = 1'b0;
      while (cyc < st2 - 1) tick();
      check("full_before_start2", full, 32'd1);
      tick();
      check("full_at_start2", {full, run}, 2'b01);
      wait_idle();

      // Reset during data bit 4 with a load in the same cycle.
      load(8'h96, 1'b0, 1'b0, 1'b0, 0, lit, 0, 0, st);
      while (cyc < st + 5 * (cpb_cur + 1) + 1) tick();
      mon_abort  = 1'b1;
      reset      = 1'b1;
      dataIn     = 8'h77;
      loadDataIn = 1'b1;
      tick();
      reset      = 1'b0;
      loadDataIn = 1'b0;
      m_full_until = -1;
      m_last_end   = -1;
      check("mid_frame_reset", {serialOut, run, full, overrunErrorFlag}, 4'b1000);
      mon_abort = 1'b0;
      tick();
      load(8'h3C, 1'b1, 1'b1, 1'b0, 0, lit, 0, 0, st);
      wait_idle();

      // Randomized bursts; options wander whenever no byte is waiting to be framed.
      for (int b = 0; b < 6; b++) begin
         cpb_cur = $urandom_range(1, 5);
         clocksPerBit = W'(cpb_cur);
         tick();
         for (int i = 0; i < 12; i++) begin
            int gap;
            gap = $urandom_range(0, 60);
            for (int g = 0; g < gap; g++) begin
               if (cyc > m_full_until) {msbFirst, oddParity, stopBit2} = 3'($urandom);
               tick();
            end
            load(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0, lit, 0, 0, st);
            check("rand_overrun_flag", overrunErrorFlag, (st < 0));
            if (st < 0) begin
               ackFlags = 1'b1;
               tick();
               ackFlags = 1'b0;
               check("rand_overrun_ack", overrunErrorFlag, 32'd0);
            end
         end
         wait_idle();
      end

      // Receiver rejects every attempt: retransmissions only when detection is built in.
      cpb_cur = 3;
      clocksPerBit = W'(cpb_cur);
      nack_mode = 1'b1;
      tick();
      load(8'h3B, 1'b0, 1'b0, 1'b0, ERR_EN ? 3 : 0, lit, 0, 0, st);
      check("frame_err_before", frameErrorFlag, 32'd0);
      wait_idle();
      check("frame_err_after", frameErrorFlag, ERR_EN);
      nack_mode = 1'b0;
      ackFlags  = 1'b1;
      tick();
      ackFlags  = 1'b0;
      check("frame_err_ack", frameErrorFlag, 32'd0);
      load(8'h81, 1'b1, 1'b0, 1'b1, 0, lit, 0, 0, st);
      wait_idle();
      check("final_flags", {overrunErrorFlag, frameErrorFlag, full, run}, 4'b0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
